// File: rtl/db9md_pad_reader.sv
// Two-port Mega Drive DB9 pad scanner behind a select splitter; six-button decode when DB9MD_SIX_BUTTON_EN is defined.
// Free-running with no backpressure: each port's word updates one clock after its last phase sample.
module db9md_pad_reader #(
  parameter int STEP_CYCLES = 500,
  parameter int IDLE_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [5:0]  joy_in,
  output logic        joy_split,
  output logic        joy_mdsel,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2
);

  localparam int TMAX = (IDLE_CYCLES > STEP_CYCLES) ? IDLE_CYCLES : STEP_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_CYCLES - 1);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
`ifdef DB9MD_SIX_BUTTON_EN
  localparam logic [2:0] LAST_PH = 3'd7;
`else
  localparam logic [2:0] LAST_PH = 3'd1;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN1, ST_SCAN2} state_t;

  state_t        state;
  logic [2:0]    phase;
  logic [TW-1:0] timer;
  logic [11:0]   sh_btn;
  logic          sh_md;
`ifdef DB9MD_SIX_BUTTON_EN
  logic          sh_six;
  logic          nxt_six;
`endif
  logic [5:0]    smp;
  logic [11:0]   nxt_btn;
  logic          nxt_md;
  logic [15:0]   word;

  // Shadow state as it would look after this clock's sample, plus the gated output word.
  always_comb begin
    smp     = ~joy_in;
    nxt_btn = sh_btn;
    nxt_md  = sh_md;
`ifdef DB9MD_SIX_BUTTON_EN
    nxt_six = sh_six;
`endif
    case (phase)
      3'd0: begin
        nxt_btn[3:0] = {smp[0], smp[1], smp[2], smp[3]};
        nxt_btn[5:4] = smp[5:4];
      end
      3'd1: begin
        nxt_md       = smp[2] & smp[3];
        nxt_btn[7:6] = smp[5:4];
      end
`ifdef DB9MD_SIX_BUTTON_EN
      3'd5: nxt_six = sh_md & (&smp[3:0]);
      3'd6: nxt_btn[11:8] = {smp[0], smp[1], smp[2], smp[3]} & {4{sh_six}};
`endif
      default: ;
    endcase
    word = {4'h0, nxt_btn};
    if (!nxt_md) word[11:6] = 6'h00;
`ifndef DB9MD_SIX_BUTTON_EN
    word[11:8] = 4'h0;
`endif
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= ST_IDLE;
      phase     <= 3'd0;
      timer     <= '0;
      joy_split <= 1'b0;
      joy_mdsel <= 1'b1;
      joystick1 <= 16'h0000;
      joystick2 <= 16'h0000;
      sh_btn    <= 12'h000;
      sh_md     <= 1'b0;
`ifdef DB9MD_SIX_BUTTON_EN
      sh_six    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (timer == IDLE_LAST) begin
            timer     <= '0;
            state     <= ST_SCAN1;
            phase     <= 3'd0;
            joy_mdsel <= 1'b1;
            joy_split <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          if (timer == STEP_LAST) begin
            timer  <= '0;
            sh_btn <= nxt_btn;
            sh_md  <= nxt_md;
`ifdef DB9MD_SIX_BUTTON_EN
            sh_six <= nxt_six;
`endif
            if (phase == LAST_PH) begin
              // Split flips together with SELECT rising into the next port's P0.
              phase     <= 3'd0;
              joy_mdsel <= 1'b1;
              if (state == ST_SCAN1) begin
                joystick1 <= word;
                state     <= ST_SCAN2;
                joy_split <= 1'b1;
              end else begin
                joystick2 <= word;
                state     <= ST_IDLE;
                joy_split <= 1'b0;
              end
            end else begin
              phase     <= phase + 3'd1;
              joy_mdsel <= phase[0];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_db9md_pad_reader.sv
// Randomised bench for db9md_pad_reader: behavioural pads on both ports, expected words from button sets.
module tb_db9md_pad_reader;

  localparam int STEP = 16;
  localparam int IDLE = 200;
`ifdef DB9MD_SIX_BUTTON_EN
  localparam int NPH = 8;
  localparam logic [11:0] HI_MASK = 12'hFFF;
`else
  localparam int NPH = 2;
  localparam logic [11:0] HI_MASK = 12'h0FF;
`endif
  localparam int PER = IDLE + 2 * NPH * STEP;
  localparam int RPH = (NPH > 3) ? 3 : 1;
  localparam int T_NONE = 0, T_3B = 1, T_6B = 2, T_ATARI = 3;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [5:0]  joy_in;
  logic        joy_split, joy_mdsel;
  logic [15:0] joystick1, joystick2;

  always #5 clk = ~clk;

  db9md_pad_reader #(.STEP_CYCLES(STEP), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .RESET(RESET), .joy_in(joy_in), .joy_split(joy_split),
    .joy_mdsel(joy_mdsel), .joystick1(joystick1), .joystick2(joystick2)
  );

  int checks = 0, failures = 0;
  int cyc = 0, base = 0;
  int ph = 0, hi_run = 0;
  logic pv_split = 1'b0, pv_sel = 1'b1;
  int t1 = T_NONE, t2 = T_NONE;
  logic [11:0] b1 = 12'h0, b2 = 12'h0;
  logic [15:0] e1 = 16'h0, e2 = 16'h0;

  always @(posedge clk) if (RESET) cyc <= 0; else cyc <= cyc + 1;

  // Button layout: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]St [8]M [9]X [10]Y [11]Z.
  function automatic logic [5:0] pad_lines(input int typ, input logic [11:0] b, input int p, input logic sel);
    logic [5:0] act;
    act = {b[5], b[4], b[0], b[1], b[2], b[3]};
    case (typ)
      T_ATARI: ;
      T_3B, T_6B: begin
        if (sel) begin
          if (typ == T_6B && p == 6) act = {b[5], b[4], b[8], b[9], b[10], b[11]};
        end else if (typ == T_6B && p == 5) act = {b[7], b[6], 4'b1111};
        else if (typ == T_6B && p == 7) act = {b[7], b[6], 4'b0000};
        else act = {b[7], b[6], 1'b1, 1'b1, b[2], b[3]};
      end
      default: act = 6'h00;
    endcase
    return ~act;
  endfunction

  function automatic logic [15:0] exp_word(input int typ, input logic [11:0] b);
    case (typ)
      T_3B:    return {4'h0, b & 12'h0FF};
      T_6B:    return {4'h0, b & HI_MASK};
      T_ATARI: return {4'h0, b & 12'h03F};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [11:0] gen_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[3] && b[2]) b[2] = 1'b0;
    if (b[1] && b[0]) b[0] = 1'b0;
    return b;
  endfunction

  // Pad-side select counter: restarts on port switch or a long SELECT-high timeout.
  always @(negedge clk) begin
    if (joy_split != pv_split) ph = 0;
    else if (joy_mdsel != pv_sel) ph = ph + 1;
    if (joy_mdsel) hi_run = hi_run + 1; else hi_run = 0;
    if (hi_run > 3 * STEP) ph = 0;
    pv_split = joy_split;
    pv_sel   = joy_mdsel;
  end

  always @* joy_in = joy_split ? pad_lines(t2, b2, ph, joy_mdsel) : pad_lines(t1, b1, ph, joy_mdsel);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 4 * PER) begin
      tick();
      guard++;
    end
    check("wait_cyc", 16'(cyc), 16'(n));
  endtask

  task automatic run_scan(input int nt1, input logic [11:0] nb1, input int nt2, input logic [11:0] nb2,
                          input bit mid_en, input int mt1, input logic [11:0] mb1,
                          input bit late_en, input int lt1, input logic [11:0] lb1);
    logic [15:0] p1, p2;
    int c1;
    p1 = e1; p2 = e2;
    t1 = nt1; b1 = nb1; t2 = nt2; b2 = nb2;
    e1 = exp_word(nt1, nb1);
    e2 = exp_word(nt2, nb2);
    c1 = base + IDLE + NPH * STEP;
    wait_cyc(base + IDLE / 2);
    check("idle_sel", 16'(joy_mdsel), 16'h1);
    check("idle_split", 16'(joy_split), 16'h0);
    wait_cyc(base + IDLE + STEP / 2);
    if (mid_en) begin
      t1 = mt1; b1 = mb1;
      e1 = exp_word(mt1, mb1);
    end
    wait_cyc(base + IDLE + STEP - 1);
    check("sel_pre_fall", 16'(joy_mdsel), 16'h1);
    tick();
    check("sel_fall", 16'(joy_mdsel), 16'h0);
    wait_cyc(c1 - 1);
    check("j1_hold", joystick1, p1);
    tick();
    check("j1_upd", joystick1, e1);
    check("j2_hold_a", joystick2, p2);
    if (late_en) begin
      t1 = lt1; b1 = lb1;
    end
    wait_cyc(c1 + STEP / 2);
    check("p2_split", 16'(joy_split), 16'h1);
    check("p2_sel", 16'(joy_mdsel), 16'h1);
    wait_cyc(base + PER - 1);
    check("j2_hold", joystick2, p2);
    tick();
    check("j2_upd", joystick2, e2);
    check("j1_keep", joystick1, e1);
    base = base + PER;
  endtask

  initial begin
    t1 = T_ATARI; b1 = gen_btn(); t2 = T_6B; b2 = gen_btn();
    RESET = 1'b1;
    repeat (5) begin
      tick();
      check("rst_j1", joystick1, 16'h0);
      check("rst_j2", joystick2, 16'h0);
      check("rst_sel", 16'(joy_mdsel), 16'h1);
      check("rst_split", 16'(joy_split), 16'h0);
    end
    RESET = 1'b0;
    base = 0; e1 = 16'h0; e2 = 16'h0;

    // Abandon a scan inside port 2's sequence; port 2 must stay clear.
    t1 = T_3B; b1 = 12'h041; t2 = T_6B; b2 = 12'h980;
    wait_cyc(IDLE + NPH * STEP + RPH * STEP + STEP / 2);
    check("j1_pre_rst", joystick1, exp_word(T_3B, 12'h041));
    check("j2_pre_rst", joystick2, 16'h0);
    RESET = 1'b1;
    repeat (3) begin
      tick();
      check("rst_mid_j2", joystick2, 16'h0);
    end
    check("rst_mid_j1", joystick1, 16'h0);
    RESET = 1'b0;
    base = 0; e1 = 16'h0; e2 = 16'h0;
    run_scan(T_3B, 12'h041, T_6B, 12'h980, 0, 0, 12'h0, 0, 0, 12'h0);

    run_scan(T_3B, 12'h041, T_NONE, 12'h000, 0, 0, 12'h0, 0, 0, 12'h0);
    check("dir_3b_a_right", joystick1, 16'h0041);
    run_scan(T_ATARI, 12'h0D8, T_6B, 12'h980, 0, 0, 12'h0, 0, 0, 12'h0);
    check("dir_atari", joystick1, 16'h0018);
`ifdef DB9MD_SIX_BUTTON_EN
    check("dir_6b", joystick2, 16'h0980);
`else
    check("dir_6b", joystick2, 16'h0080);
`endif

    // Mid-P0 change is caught this scan; change after port 1's last sample lands next scan.
    run_scan(T_3B, 12'h001, T_NONE, 12'h000, 1, T_3B, 12'h030, 1, T_6B, 12'h0C4);
    run_scan(T_6B, 12'h0C4, T_3B, 12'h082, 0, 0, 12'h0, 0, 0, 12'h0);

    repeat (12) begin
      int a, c;
      logic [11:0] x, y, z;
      bit m;
      a = $urandom_range(0, 3); x = gen_btn();
      c = $urandom_range(0, 3); y = gen_btn();
      m = 1'($urandom_range(0, 1)); z = gen_btn();
      run_scan(a, x, c, y, m, a, z, 0, 0, 12'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(10 * 40 * PER);
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/db9md_pad_reader.md
# db9md_pad_reader

Scans two Mega Drive–compatible DB9 pads through the single-input splitter on the user port and presents debounced-free, active-high button words to the core's input mapping. Sits directly upstream of the arcade top level: it drives the splitter select (`joy_split`) and pad SELECT line (`joy_mdsel`), samples the shared 6-line bus (`joy_in`), and publishes `joystick1`/`joystick2` in the bit layout the top level remaps onto coin/start/fire/cheat.

## Interface
- `STEP_CYCLES`, 500: clocks per SELECT phase (10 µs at 50 MHz); legal range 16–4095.
- `IDLE_CYCLES`, 100000: clocks SELECT held high between scans (2 ms at 50 MHz); must exceed the pad's 1.5 ms six-button counter timeout.
- `clk`  in  1  system clock, 35–50 MHz.
- `RESET`  in  1  synchronous, active-high reset.
- `joy_in`  in  6  shared pad lines, active-low: [0] Up, [1] Down, [2] Left, [3] Right, [4] pin 6 (B/A), [5] pin 9 (C/Start).
- `joy_split`  out  1  splitter select: 0 = port 1, 1 = port 2.
- `joy_mdsel`  out  1  pad SELECT line.
- `joystick1`  out  16  port 1 buttons, active-high.
- `joystick2`  out  16  port 2 buttons, active-high.
- Output word layout: [0] Right, [1] Left, [2] Down, [3] Up, [4] B, [5] C, [6] A, [7] Start, [8] Mode, [9] X, [10] Y, [11] Z, [15:12] = 0.

## Operation
- FSM states:
  - IDLE: `joy_split`=0, `joy_mdsel`=1, for `IDLE_CYCLES`.
  - SCAN1: port 1, phases P0–P7, `joy_split`=0.
  - SCAN2: port 2, phases P0–P7, `joy_split`=1.
  - Then back to IDLE.
- Each phase lasts `STEP_CYCLES` clocks.
  - `joy_mdsel` = 1 in even phases, 0 in odd phases.
  - `joy_in` is sampled (inverted to active-high) on the last clock of the phase.
- Decode per phase (values active-high after inversion):
  - P0 (sel=1): Up, Down, Left, Right, B = bit4, C = bit5.
  - P1 (sel=0): pad-present flag `md` = Left & Right; A = bit4, Start = bit5.
  - P2–P4: no decode.
  - P5 (sel=0): `six` = `md` & Up & Down & Left & Right.
  - P6 (sel=1): if `six`, then Z = Up, Y = Down, X = Left, Mode = Right; otherwise these four are 0.
  - P7 (sel=0): no decode.
- If `md`=0 (non-MD joystick or no pad): A, Start, X, Y, Z and Mode are forced to 0. Directions, B and C still come from P0.
- Per-port results are built in a shadow register and copied to `joystick1`/`joystick2` only when that port's P7 completes. No partial update is ever visible.
- `joy_split` changes on the same clock `joy_mdsel` rises from P7 to the next port's P0. P0's full step is the splitter settle time.

## Timing
- Reset values: `joystick1`=`joystick2`=16'h0000, `joy_mdsel`=1, `joy_split`=0, FSM=IDLE, timers=0.
- `RESET` asserted mid-scan abandons the scan without updating outputs. IDLE restarts the cycle after `RESET` deasserts.
- Select edges occur on the clock after each sample clock (phase boundary).
- Output latency: a sample taken at clock N (P7 end) appears on `joystickX` at N+1.
- Scan period: `IDLE_CYCLES` + 16·`STEP_CYCLES` clocks (108000 default). Each port updates once per period.
- Timer width: ⌈log2(max(`IDLE_CYCLES`,`STEP_CYCLES`))⌉ bits. The timer wraps to 0 at every state/phase boundary.

## Configuration
- `DB9MD_SIX_BUTTON_EN`:
  - Defined: full P0–P7 sequence and six-button decode as above.
  - Undefined:
    - Each scan runs only P0–P1; SCAN2 P0 follows SCAN1 P1 directly.
    - The output update point moves to P1 end.
    - Bits [11:8] are constant 0.
    - Scan period is `IDLE_CYCLES` + 4·`STEP_CYCLES`.

## Test plan
- Reset: hold `RESET` 5 clocks with arbitrary `joy_in` -> outputs 0, `joy_mdsel`=1, `joy_split`=0; first `joy_mdsel` fall at clock `IDLE_CYCLES`+`STEP_CYCLES` after release.
- 3-button pad model on port 1 pressing A+Right, port 2 idle (all lines high) -> `joystick1`=16'h0041, `joystick2`=16'h0000 after the first full scan.
- 6-button pad model on port 2 pressing Start+Z+Mode -> `joystick2`=16'h0980. Same with `DB9MD_SIX_BUTTON_EN` undefined -> 16'h0080.
- Atari stick (P1 Left/Right not both low) holding Up+pin6 -> `joystick1`=16'h0018, A/Start 0.
- Reset pulse during SCAN2 P3 with new port 2 stimulus -> `joystick2` holds 0, no glitch. Next complete scan shows the new value.
- Pad model asserts a button change mid-P0 before the sample clock -> captured in that scan. A change after the P7 sample -> appears only in the next scan, exactly one scan period later.
